// File: rtl/wb_mon_pkg.sv
// wb_mon_pkg: error codes and state-encoding helpers for the Wishbone burst FSM monitor
package wb_mon_pkg;
  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_ILLEGAL = 3'd1;
  localparam logic [2:0] ERR_IDLE    = 3'd2;
  localparam logic [2:0] ERR_ADVANCE = 3'd3;
  localparam logic [2:0] ERR_HOLD    = 3'd4;
  localparam logic [2:0] ERR_WAIT    = 3'd5;
  localparam logic [2:0] ERR_TIMEOUT = 3'd6;
  function automatic logic idle(int s);
    return s == 0;
  endfunction
  function automatic logic wait_ack(int s, int bl);
    return s == bl;
  endfunction
  function automatic logic is_burst(int s, int bl);
    return s >= 1 && s < bl;
  endfunction
endpackage

// File: rtl/wb_fsm_burst_monitor_if.sv
// wb_fsm_burst_monitor_if: tap of the Wishbone master burst FSM state, ack and extra-write flag
interface wb_fsm_burst_monitor_if #(parameter int STATE_W = 3);
  logic [STATE_W-1:0] state;
  logic               wb_ack;
  logic               extra_write;
  modport master (output state, wb_ack, extra_write);
  modport slave  (input  state, wb_ack, extra_write);
endinterface

// File: rtl/wb_mon_dwell_timer.sv
// wb_mon_dwell_timer: counts consecutive repeats of a non-IDLE state, fires once on reaching TIMEOUT
module wb_mon_dwell_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  input  logic i_same,
  output logic o_fire
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] L_MAX = W'(TIMEOUT);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk)
    if (i_rst || !i_enable || !i_same) r_cnt <= '0;
    else if (r_cnt != L_MAX) r_cnt <= r_cnt + W'(1);
  assign o_fire = i_enable && i_same && r_cnt == L_MAX - W'(1);
endmodule

// File: rtl/wb_fsm_burst_monitor.sv
// wb_fsm_burst_monitor: run-time transition/hold/timeout checker for the Wishbone master burst FSM
module wb_fsm_burst_monitor
  import wb_mon_pkg::*;
#(
  parameter int BURST_LEN   = 4,
  parameter int STATE_W     = 3,
  parameter int TIMEOUT     = 1000,
  parameter int STRICT_HOLD = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_clr,
  wb_fsm_burst_monitor_if.slave i_tap,
  output logic                  o_err,
  output logic                  o_err_sticky,
  output logic [2:0]            o_err_code,
  output logic [STATE_W-1:0]    o_err_prev,
  output logic [STATE_W-1:0]    o_err_next,
  output logic [CNT_W-1:0]      o_err_cnt,
  output logic [CNT_W-1:0]      o_burst_cnt
);
  logic [STATE_W-1:0] r_prev_state;
  logic r_prev_ack, r_prev_extra, r_prev_valid;
  logic w_chk, w_illegal, w_c2, w_c3, w_c4, w_c5, w_same, w_fire, w_done, w_err, w_cap;
  logic [2:0] w_code;
  int w_prev, w_next;
  assign w_prev    = int'(r_prev_state);
  assign w_next    = int'(i_tap.state);
  assign w_chk     = i_enable && r_prev_valid;
  assign w_illegal = i_enable && w_next > BURST_LEN;
  assign w_c2 = w_chk && idle(w_prev) && !(idle(w_next) || w_next == 1 || wait_ack(w_next, BURST_LEN));
  assign w_c3 = w_chk && is_burst(w_prev, BURST_LEN) && r_prev_ack && w_next != w_prev + 1;
  assign w_c4 = w_chk && STRICT_HOLD != 0 && is_burst(w_prev, BURST_LEN) && !r_prev_ack && w_next != w_prev;
  assign w_c5 = w_chk && wait_ack(w_prev, BURST_LEN) &&
                ((r_prev_extra || !r_prev_ack) ? !wait_ack(w_next, BURST_LEN) : !idle(w_next));
  assign w_done = w_chk && wait_ack(w_prev, BURST_LEN) && !r_prev_extra && r_prev_ack && idle(w_next);
  assign w_same = r_prev_valid && w_next == w_prev && !idle(w_prev);
  wb_mon_dwell_timer #(.TIMEOUT(TIMEOUT)) u_dwell (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_enable (i_enable),
    .i_same   (w_same),
    .o_fire   (w_fire)
  );
  assign w_code = w_illegal ? ERR_ILLEGAL :
                  w_c2      ? ERR_IDLE    :
                  w_c3      ? ERR_ADVANCE :
                  w_c4      ? ERR_HOLD    :
                  w_c5      ? ERR_WAIT    :
                  w_fire    ? ERR_TIMEOUT : ERR_NONE;
  assign w_err = w_code != ERR_NONE;
  // a clear in the same cycle discards the old record, so the new error is captured
  assign w_cap = w_err && (i_clr || !o_err_sticky);
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_prev_state <= '0;
      r_prev_ack   <= 1'b0;
      r_prev_extra <= 1'b0;
      r_prev_valid <= 1'b0;
      o_err        <= 1'b0;
      o_err_sticky <= 1'b0;
      o_err_code   <= ERR_NONE;
      o_err_prev   <= '0;
      o_err_next   <= '0;
      o_err_cnt    <= '0;
      o_burst_cnt  <= '0;
    end else begin
      r_prev_valid <= i_enable;
      if (i_enable) begin
        r_prev_state <= i_tap.state;
        r_prev_ack   <= i_tap.wb_ack;
        r_prev_extra <= i_tap.extra_write;
      end
      o_err        <= w_err;
      o_err_sticky <= (o_err_sticky && !i_clr) || w_err;
      if (w_cap) begin
        o_err_code <= w_code;
        o_err_prev <= r_prev_state;
        o_err_next <= i_tap.state;
      end else if (i_clr) begin
        o_err_code <= ERR_NONE;
        o_err_prev <= '0;
        o_err_next <= '0;
      end
      o_err_cnt   <= i_clr ? CNT_W'(w_err)  : o_err_cnt + CNT_W'(w_err && !(&o_err_cnt));
      o_burst_cnt <= i_clr ? CNT_W'(w_done) : o_burst_cnt + CNT_W'(w_done && !(&o_burst_cnt));
    end
endmodule

// File: tb/tb_wb_fsm_burst_monitor.sv
// tb_wb_fsm_burst_monitor: table-driven and directed checks of the burst FSM monitor
module tb_wb_fsm_burst_monitor;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0;
  always #5 clk = ~clk;
  wb_fsm_burst_monitor_if #(.STATE_W(3)) tap_a ();
  wb_fsm_burst_monitor_if #(.STATE_W(4)) tap_b ();
  logic a_err, a_sticky, b_err, b_sticky;
  logic [2:0] a_code, a_pv, a_nx, b_code;
  logic [3:0] b_pv, b_nx;
  logic [15:0] a_cnt, a_bcnt, b_cnt, b_bcnt;
  wb_fsm_burst_monitor #(.BURST_LEN(4), .STATE_W(3), .TIMEOUT(8)) u_a (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_clr(clr), .i_tap(tap_a),
    .o_err(a_err), .o_err_sticky(a_sticky), .o_err_code(a_code), .o_err_prev(a_pv),
    .o_err_next(a_nx), .o_err_cnt(a_cnt), .o_burst_cnt(a_bcnt)
  );
  wb_fsm_burst_monitor #(.BURST_LEN(8), .STATE_W(4)) u_b (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_clr(clr), .i_tap(tap_b),
    .o_err(b_err), .o_err_sticky(b_sticky), .o_err_code(b_code), .o_err_prev(b_pv),
    .o_err_next(b_nx), .o_err_cnt(b_cnt), .o_burst_cnt(b_bcnt)
  );
  typedef struct {
    logic [3:0] st;
    logic ack, ex, c, e, err;
    int code, pv, nx, cnt, bcnt;
    logic sticky;
  } vec_t;
  vec_t tv[24];
  int n_pass = 0, n_total = 0, pulses, at;
  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic apply(input bit sel_b, input logic [3:0] st, input logic ack, ex, c, e, r);
    @(negedge clk);
    if (sel_b) begin
      tap_b.state = st; tap_b.wb_ack = ack; tap_b.extra_write = ex;
    end else begin
      tap_a.state = st[2:0]; tap_a.wb_ack = ack; tap_a.extra_write = ex;
    end
    clr = c; en = e; rst = r;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_a_zero(input string nm);
    chk({nm, " err"}, int'(a_err), 0);
    chk({nm, " sticky"}, int'(a_sticky), 0);
    chk({nm, " code"}, int'(a_code), 0);
    chk({nm, " prev"}, int'(a_pv), 0);
    chk({nm, " next"}, int'(a_nx), 0);
    chk({nm, " cnt"}, int'(a_cnt), 0);
    chk({nm, " bcnt"}, int'(a_bcnt), 0);
  endtask
  initial begin
    tap_a.state = '0; tap_a.wb_ack = 1'b0; tap_a.extra_write = 1'b0;
    tap_b.state = '0; tap_b.wb_ack = 1'b0; tap_b.extra_write = 1'b0;
    //          st ack ex clr en | err code pv nx cnt bcnt sticky
    tv = '{
      '{4'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0},
      '{4'd1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0},
      '{4'd2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0},
      '{4'd3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0},
      '{4'd4, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0},
      '{4'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0},
      '{4'd1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0},
      '{4'd3, 0, 0, 0, 1, 1, 3, 1, 3, 1, 1, 1},
      '{4'd3, 0, 0, 0, 1, 0, 3, 1, 3, 1, 1, 1},
      '{4'd3, 1, 0, 0, 1, 0, 3, 1, 3, 1, 1, 1},
      '{4'd4, 1, 1, 0, 1, 0, 3, 1, 3, 1, 1, 1},
      '{4'd4, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0},
      '{4'd0, 0, 0, 0, 1, 1, 5, 4, 0, 1, 0, 1},
      '{4'd7, 0, 0, 0, 1, 1, 5, 4, 0, 2, 0, 1},
      '{4'd0, 0, 0, 0, 1, 0, 5, 4, 0, 2, 0, 1},
      '{4'd2, 0, 0, 1, 1, 1, 2, 0, 2, 1, 0, 1},
      '{4'd2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0},
      '{4'd3, 0, 0, 0, 1, 1, 4, 2, 3, 1, 0, 1},
      '{4'd3, 0, 0, 0, 0, 0, 4, 2, 3, 1, 0, 1},
      '{4'd1, 0, 0, 0, 1, 0, 4, 2, 3, 1, 0, 1},
      '{4'd4, 0, 0, 0, 1, 1, 4, 2, 3, 2, 0, 1},
      '{4'd4, 0, 0, 0, 1, 0, 4, 2, 3, 2, 0, 1},
      '{4'd4, 1, 0, 0, 1, 0, 4, 2, 3, 2, 0, 1},
      '{4'd0, 0, 0, 0, 1, 0, 4, 2, 3, 2, 1, 1}
    };
    repeat (3) @(posedge clk);
    #1;
    chk_a_zero("reset");
    for (int i = 0; i < 24; i++) begin
      apply(1'b0, tv[i].st, tv[i].ack, tv[i].ex, tv[i].c, tv[i].e, 1'b0);
      chk($sformatf("v%0d err", i), int'(a_err), int'(tv[i].err));
      chk($sformatf("v%0d code", i), int'(a_code), tv[i].code);
      chk($sformatf("v%0d prev", i), int'(a_pv), tv[i].pv);
      chk($sformatf("v%0d next", i), int'(a_nx), tv[i].nx);
      chk($sformatf("v%0d cnt", i), int'(a_cnt), tv[i].cnt);
      chk($sformatf("v%0d bcnt", i), int'(a_bcnt), tv[i].bcnt);
      chk($sformatf("v%0d sticky", i), int'(a_sticky), int'(tv[i].sticky));
    end
    // dwell in BURST2 without ack: the 8th repeat edge raises the single timeout
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("to clr cnt", int'(a_cnt), 0);
    apply(1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    pulses = 0;
    at = 0;
    for (int i = 1; i <= 20; i++) begin
      apply(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (a_err) begin
        pulses++;
        at = i;
        chk("to code", int'(a_code), 6);
        chk("to cnt", int'(a_cnt), 1);
        chk("to prev", int'(a_pv), 2);
      end
    end
    chk("to pulses", pulses, 1);
    chk("to edge", at, 9);
    // reset mid-burst: an otherwise illegal 3->0 after reset is not checked
    apply(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_a_zero("rst");
    apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_a_zero("post rst");
    // BURST_LEN=8 instance: full legal burst, then an illegal encoding
    for (int s = 0; s <= 8; s++) begin
      apply(1'b1, 4'(s), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("b8 s%0d err", s), int'(b_err), 0);
    end
    apply(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("b8 done err", int'(b_err), 0);
    chk("b8 bcnt", int'(b_bcnt), 1);
    chk("b8 sticky", int'(b_sticky), 0);
    apply(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("b8 ill err", int'(b_err), 1);
    chk("b8 ill code", int'(b_code), 1);
    chk("b8 ill prev", int'(b_pv), 0);
    chk("b8 ill next", int'(b_nx), 9);
    chk("b8 ill cnt", int'(b_cnt), 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
